// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared types and constants for the vector RAM port arbiter
package vram_pkg;

   typedef enum logic [1:0] {IDLE, DRAIN, GO} vramGoState_t;

   localparam logic [15:0] VRAM_BASE  = 16'h2000;
   localparam logic [15:0] VRAM_LIMIT = 16'h4000;

   function automatic logic in_vram_range(input logic [15:0] addr);
      return (addr >= VRAM_BASE) && (addr < VRAM_LIMIT);
   endfunction

endpackage

// File: rtl/vram_go_sync.sv
// rtl/vram_go_sync.sv - holds the CPU go strobe until the store queue has drained
module vram_go_sync
   import vram_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic vggoIn,
   input  logic storeEmpty,
   output logic vgGo,
   output logic draining
);

   vramGoState_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A go strobe seen outside IDLE is dropped, not queued.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (vggoIn) state_d = DRAIN;
         DRAIN:   if (storeEmpty) state_d = GO;
         GO:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vgGo     = (state_q == GO);
      draining = (state_q == DRAIN);
   end

endmodule

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - shares the vector BRAM between VG fetch and CPU store drain
module vram_port_arbiter
   import vram_pkg::*;
#(
   parameter int ADDR_W     = 13,
   parameter int MAX_STARVE = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        storeData,
   input  logic [15:0]       storeAddr,
   input  logic              storeValid,
   input  logic              storeEmpty,
   output logic              storeCanWrite,
   input  logic              vgReq,
   input  logic [ADDR_W-1:0] vgAddr,
   output logic              vgGnt,
   output logic [7:0]        vgData,
   output logic              vgDataValid,
   input  logic              vggoIn,
   output logic              vgGo,
   output logic [ADDR_W-1:0] bramAddr,
   output logic [7:0]        bramDin,
   output logic              bramWe,
   input  logic [7:0]        bramDout,
   output logic              dropErr
);

   localparam int CNT_W = $clog2(MAX_STARVE + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(MAX_STARVE);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             vgdv_q, vgdv_d;
   logic             drop_q, drop_d;
   logic             draining;
   logic             store_gnt;
   logic             vg_gnt;
   logic             in_range;

   vram_go_sync u_go_sync (
      .clk        (clk),
      .rst        (rst),
      .vggoIn     (vggoIn),
      .storeEmpty (storeEmpty),
      .vgGo       (vgGo),
      .draining   (draining)
   );

   always_comb begin
      in_range  = in_vram_range(storeAddr);
      store_gnt = !rst && !storeEmpty &&
                  (draining || !vgReq || (starve_q == STARVE_MAX));
      vg_gnt    = !rst && vgReq && !store_gnt;

      storeCanWrite = store_gnt;
      vgGnt         = vg_gnt;
      bramWe        = store_gnt && storeValid && in_range;
      bramAddr      = bramWe ? storeAddr[ADDR_W-1:0] : vgAddr;
      bramDin       = storeData;
      vgData        = bramDout;
      vgDataValid   = vgdv_q;
      dropErr       = drop_q;
   end

   // Counts VG wins while stores wait; saturates so the store gets the next slot.
   always_comb begin
      starve_d = starve_q;
      if (store_gnt || storeEmpty)
         starve_d = '0;
      else if (vg_gnt && (starve_q != STARVE_MAX))
         starve_d = starve_q + 1'b1;

      vgdv_d = vg_gnt;
      drop_d = drop_q || (store_gnt && storeValid && !in_range);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
         vgdv_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         starve_q <= starve_d;
         vgdv_q   <= vgdv_d;
         drop_q   <= drop_d;
      end
   end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - directed vector bench for vram_port_arbiter
module tb_vram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  storeData;
   logic [15:0] storeAddr;
   logic        storeValid;
   logic        storeEmpty;
   logic        storeCanWrite;
   logic        vgReq;
   logic [12:0] vgAddr;
   logic        vgGnt;
   logic [7:0]  vgData;
   logic        vgDataValid;
   logic        vggoIn;
   logic        vgGo;
   logic [12:0] bramAddr;
   logic [7:0]  bramDin;
   logic        bramWe;
   logic [7:0]  bramDout;
   logic        dropErr;

   always #5 clk = ~clk;

   vram_port_arbiter #(.ADDR_W(13), .MAX_STARVE(16)) dut (
      .clk (clk), .rst (rst),
      .storeData (storeData), .storeAddr (storeAddr), .storeValid (storeValid),
      .storeEmpty (storeEmpty), .storeCanWrite (storeCanWrite),
      .vgReq (vgReq), .vgAddr (vgAddr), .vgGnt (vgGnt),
      .vgData (vgData), .vgDataValid (vgDataValid),
      .vggoIn (vggoIn), .vgGo (vgGo),
      .bramAddr (bramAddr), .bramDin (bramDin), .bramWe (bramWe),
      .bramDout (bramDout), .dropErr (dropErr)
   );

   // Store queue model: tail written by the stimulus, head by the pop logic.
   logic        direct;
   logic        tv_empty, tv_valid;
   logic [15:0] tv_addr;
   logic [7:0]  tv_data;
   logic [15:0] q_addr [0:15];
   logic [7:0]  q_data [0:15];
   int          q_tail = 0;
   int          q_head = 0;
   logic        q_empty;

   assign q_empty    = (q_head == q_tail);
   assign storeEmpty = direct ? tv_empty : q_empty;
   assign storeValid = direct ? tv_valid : (storeCanWrite && !q_empty);
   assign storeAddr  = direct ? tv_addr  : q_addr[q_head % 16];
   assign storeData  = direct ? tv_data  : q_data[q_head % 16];

   always @(posedge clk)
      if (!direct && storeCanWrite && storeValid) q_head <= q_head + 1;

   // Single-port BRAM with registered read.
   logic [7:0] mem [0:8191];
   always @(posedge clk) begin
      if (bramWe) mem[bramAddr] <= bramDin;
      bramDout <= mem[bramAddr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [12:0] addr;
      logic [7:0]  data;
      int          cycle;
   } wr_t;
   wr_t wlog[$];
   always @(posedge clk)
      if (bramWe) wlog.push_back('{bramAddr, bramDin, cyc});

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] d);
      q_addr[q_tail % 16] = a;
      q_data[q_tail % 16] = d;
      q_tail = q_tail + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        empty, valid;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        vgreq;
      logic [12:0] vgaddr;
      logic        e_cw, e_gnt, e_we;
      logic [12:0] e_addr;
      logic [7:0]  e_din;
      logic        e_drop;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int base, go_cnt, go_cyc, first_empty, we_cnt, last_we, cw_cyc, cw_cnt, gnt_low, dv_bad;
      logic prev_gnt;

      vecs[0] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 13'h0123, 1'b0, 1'b0, 1'b0, 13'h0123, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 13'h00AB, 1'b0, 1'b1, 1'b0, 13'h00AB, 8'h00, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 16'h2010, 8'h11, 1'b0, 13'h0001, 1'b1, 1'b0, 1'b1, 13'h0010, 8'h11, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 16'h3FFF, 8'h22, 1'b0, 13'h0001, 1'b1, 1'b0, 1'b1, 13'h1FFF, 8'h22, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 16'h2000, 8'h33, 1'b1, 13'h0077, 1'b0, 1'b1, 1'b0, 13'h0077, 8'h00, 1'b0};
      vecs[5] = '{1'b0, 1'b0, 16'h2000, 8'h44, 1'b0, 13'h0066, 1'b1, 1'b0, 1'b0, 13'h0066, 8'h00, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 16'h4000, 8'h55, 1'b0, 13'h0055, 1'b1, 1'b0, 1'b0, 13'h0055, 8'h00, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 16'h1FFF, 8'h66, 1'b0, 13'h0044, 1'b1, 1'b0, 1'b0, 13'h0044, 8'h00, 1'b1};

      direct = 1'b1; tv_empty = 1'b1; tv_valid = 1'b0; tv_addr = '0; tv_data = '0;
      vgReq = 1'b0; vgAddr = '0; vggoIn = 1'b0; rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_canwrite", storeCanWrite, 0);
      chk("rst_vggnt", vgGnt, 0);
      chk("rst_we", bramWe, 0);
      @(negedge clk);
      chk("rst_dv", vgDataValid, 0);
      chk("rst_go", vgGo, 0);
      chk("rst_drop", dropErr, 0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         tv_empty = vecs[i].empty; tv_valid = vecs[i].valid;
         tv_addr = vecs[i].addr; tv_data = vecs[i].data;
         vgReq = vecs[i].vgreq; vgAddr = vecs[i].vgaddr;
         #1;
         chk($sformatf("v%0d_canwrite", i), storeCanWrite, vecs[i].e_cw);
         chk($sformatf("v%0d_vggnt", i), vgGnt, vecs[i].e_gnt);
         chk($sformatf("v%0d_we", i), bramWe, vecs[i].e_we);
         chk($sformatf("v%0d_addr", i), bramAddr, vecs[i].e_addr);
         if (vecs[i].e_we) chk($sformatf("v%0d_din", i), bramDin, vecs[i].e_din);
         chk($sformatf("v%0d_drop", i), dropErr, vecs[i].e_drop);
         @(negedge clk);
      end

      tv_empty = 1'b1; tv_valid = 1'b0; vgReq = 1'b0;
      do_reset();
      direct = 1'b0;

      // Three stores drain back to back with no VG traffic.
      base = wlog.size();
      push(16'h2010, 8'hA0); push(16'h2011, 8'hA1); push(16'h3FFF, 8'hA2);
      gnt_low = 1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (vgGnt) gnt_low = 0;
         @(negedge clk);
      end
      chk("three_empty", storeEmpty, 1);
      chk("three_vggnt_low", gnt_low, 1);
      chk("three_count", wlog.size() - base, 3);
      if (wlog.size() - base == 3) begin
         chk("three_a0", wlog[base].addr, 13'h0010);
         chk("three_a1", wlog[base+1].addr, 13'h0011);
         chk("three_a2", wlog[base+2].addr, 13'h1FFF);
         chk("three_d2", wlog[base+2].data, 8'hA2);
         chk("three_back2back", wlog[base+2].cycle - wlog[base].cycle, 2);
      end

      // VG held for 40 cycles with one store waiting.
      push(16'h2100, 8'h33);
      vgReq = 1'b1; vgAddr = 13'h0100;
      cw_cyc = 0; cw_cnt = 0; gnt_low = 0; dv_bad = 0; prev_gnt = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         #1;
         if (storeCanWrite) begin cw_cnt++; cw_cyc = c; end
         if (!vgGnt) gnt_low++;
         if (vgDataValid !== prev_gnt) dv_bad++;
         prev_gnt = vgGnt;
         @(negedge clk);
      end
      vgReq = 1'b0;
      chk("starve_grant_cycle", cw_cyc, 17);
      chk("starve_grant_count", cw_cnt, 1);
      chk("starve_vggnt_low", gnt_low, 1);
      chk("starve_dv_follow", dv_bad, 0);

      // Write then read-back one cycle later.
      push(16'h2040, 8'h5A);
      @(negedge clk);
      vgReq = 1'b1; vgAddr = 13'h0040;
      #1;
      chk("rb_gnt", vgGnt, 1);
      @(negedge clk);
      vgReq = 1'b0;
      #1;
      chk("rb_dv", vgDataValid, 1);
      chk("rb_data", vgData, 8'h5A);

      // Out-of-range store is popped but never written.
      @(negedge clk);
      base = wlog.size();
      push(16'h1800, 8'hEE);
      @(negedge clk);
      @(negedge clk);
      chk("oor_popped", storeEmpty, 1);
      chk("oor_no_write", wlog.size() - base, 0);
      chk("oor_drop", dropErr, 1);
      repeat (5) @(negedge clk);
      chk("oor_drop_sticky", dropErr, 1);

      do_reset();
      chk("drop_cleared", dropErr, 0);

      // Go strobe with four stores queued and VG contending.
      vgReq = 1'b1; vgAddr = 13'h0010;
      push(16'h2200, 8'h01); push(16'h2201, 8'h02); push(16'h2202, 8'h03); push(16'h2203, 8'h04);
      go_cnt = 0; go_cyc = -1; first_empty = -1; we_cnt = 0; last_we = -1;
      for (int c = 0; c < 15; c++) begin
         vggoIn = (c == 0 || c == 2);
         #1;
         if (bramWe) begin we_cnt++; last_we = c; end
         if (vgGo) begin go_cnt++; go_cyc = c; end
         if (storeEmpty && first_empty < 0) first_empty = c;
         @(negedge clk);
      end
      vggoIn = 1'b0;
      chk("go_writes", we_cnt, 4);
      chk("go_pulses", go_cnt, 1);
      chk("go_cycle", go_cyc, 6);
      chk("go_after_empty", go_cyc - first_empty, 1);
      chk("go_after_writes", (last_we >= 0 && last_we < go_cyc) ? 1 : 0, 1);

      // Reset while draining loses the pending go.
      vgReq = 1'b1;
      push(16'h2300, 8'h11); push(16'h2301, 8'h12);
      vggoIn = 1'b1;
      @(negedge clk);
      vggoIn = 1'b0;
      rst = 1'b1;
      #1;
      chk("rstdrain_canwrite", storeCanWrite, 0);
      chk("rstdrain_vggnt", vgGnt, 0);
      chk("rstdrain_we", bramWe, 0);
      @(negedge clk);
      chk("rstdrain_dv", vgDataValid, 0);
      chk("rstdrain_go", vgGo, 0);
      rst = 1'b0;
      vgReq = 1'b0;
      go_cnt = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (vgGo) go_cnt++;
         @(negedge clk);
      end
      chk("rstdrain_no_go", go_cnt, 0);
      chk("rstdrain_empty", storeEmpty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares the single-port vector RAM between the vector generator's fetch port and the CPU store queue's drain side. It sits directly downstream of the `memStoreQueue` instance that buffers CPU writes to 0x2000–0x3FFF. It grants the queue's `canWrite` only when a write slot exists, translates CPU addresses to BRAM offsets, and prevents the vector generator from starving the queue. It also delays the CPU's `vggo` strobe until every queued vector-RAM write has landed, so the generator never fetches stale display lists.

## Interface
Parameters:
- ADDR_W, 13, vector BRAM address width (8 KB window)
- MAX_STARVE, 16, max consecutive vector-generator grants while stores are pending

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- storeData  in  8  queue head data (`dataOut`)
- storeAddr  in  16  queue head CPU address (`addrOut`)
- storeValid  in  1  queue head valid, already qualified by `canWrite` (`dataValid`)
- storeEmpty  in  1  queue empty flag
- storeCanWrite  out  1  drives queue `canWrite`; pop occurs in any cycle where this and storeValid are both high
- vgReq  in  1  vector generator read request; level, held until granted
- vgAddr  in  ADDR_W  vector generator read address
- vgGnt  out  1  read accepted this cycle
- vgData  out  8  read data
- vgDataValid  out  1  vgData valid
- vggoIn  in  1  CPU go strobe (decoder `vggo`); single-cycle pulse
- vgGo  out  1  go pulse to the vector generator, issued after drain
- bramAddr  out  ADDR_W  BRAM address
- bramDin  out  8  BRAM write data
- bramWe  out  1  BRAM write enable
- bramDout  in  8  BRAM read data, registered, 1-cycle latency
- dropErr  out  1  sticky flag: a store outside 0x2000–0x3FFF was discarded

## Operation
- **Arbitration** is combinational and evaluated each cycle:
  - storeGnt = !storeEmpty && (state==DRAIN || !vgReq || starveCnt==MAX_STARVE).
  - vgGnt = vgReq && !storeGnt.
  - storeCanWrite = storeGnt.
- **BRAM port mux:**
  - On storeGnt && storeValid in range: bramAddr = storeAddr[ADDR_W-1:0], bramDin = storeData, bramWe = 1.
  - On vgGnt: bramAddr = vgAddr, bramWe = 0.
  - Otherwise: bramAddr holds vgAddr, bramWe = 0.
- **Range check:** a store is in range when 16'h2000 ≤ storeAddr < 16'h4000. An out-of-range store is still popped, with bramWe=0, and sets dropErr until rst.
- **starveCnt**, width $clog2(MAX_STARVE+1):
  - Cleared to 0 on storeGnt or storeEmpty.
  - Otherwise incremented (saturating) on vgGnt.
- **Go FSM**, states IDLE, DRAIN, GO:
  - IDLE: on vggoIn, go to DRAIN.
  - DRAIN: stores take the port unconditionally. When storeEmpty is sampled high, go to GO.
  - GO: vgGo=1 for exactly one cycle, then return to IDLE.
  - vggoIn in DRAIN or GO is absorbed; it is not queued.
- **Ordering:** a write issued at edge N is visible to a read granted at cycle N+1 or later (BRAM write-before-read across cycles). No forwarding is performed.

## Timing
- Reset values:
  - state=IDLE, starveCnt=0, vgDataValid=0, vgGo=0, dropErr=0.
  - While rst is high, storeCanWrite, vgGnt and bramWe are forced to 0.
- Read latency: vgDataValid is asserted one cycle after vgGnt (registered copy of vgGnt). vgData = bramDout, combinational pass-through.
- Store latency: a write reaches the BRAM at the same edge the queue pops.
- vggoIn→vgGo with queue empty: IDLE → DRAIN at edge 1, GO at edge 2, so vgGo is high during cycle 2 (2 cycles).
- vggoIn→vgGo with queue non-empty: vgGo follows empty by 1 cycle.
- Simultaneous vggoIn and store pop: the pop proceeds, and DRAIN starts next cycle.
- rst mid-DRAIN: the FSM returns to IDLE and the pending go is lost.
- starveCnt==MAX_STARVE with vgReq held: exactly one store is granted, the counter clears, and the VG resumes the next cycle.

## Structure
- Shared package `vram_pkg`:
  - typedef enum logic [1:0] {IDLE, DRAIN, GO} vramGoState_t.
  - Constants VRAM_BASE=16'h2000 and VRAM_LIMIT=16'h4000.
- One natural sub-module, `vram_go_sync`, holds the go FSM. Its inputs are vggoIn and storeEmpty; its outputs are vgGo and a draining flag.
- Arbitration, range check and starve counter stay in the top module.
- Expected size: ~150–250 lines.

## Test plan
- Queue holds 3 stores (0x2010, 0x2011, 0x3FFF) with vgReq low → three consecutive bramWe pulses at offsets 0x010, 0x011, 0x1FFF; storeEmpty then high; vgGnt=0 throughout.
- vgReq held high for 40 cycles with 1 store pending, MAX_STARVE=16 → store granted at the 17th cycle, vgGnt low that cycle only, vgDataValid follows every vgGnt by 1 cycle.
- Store to 0x2040=0x5A, then VG read of 0x040 one cycle later → vgData=0x5A with vgDataValid.
- Store to 0x1800 → popped, bramWe stays 0, dropErr=1 and remains set until rst.
- vggoIn with 4 stores queued and vgReq high → all 4 written before vgGo; vgGo is a 1-cycle pulse the cycle after empty; a second vggoIn during DRAIN produces no extra pulse.
- rst asserted in DRAIN → vgGo never pulses; all outputs return to reset values next cycle.
